// File: rtl/uart_loader_pkg.sv
// Shared types and frame constants for the UART boot loader.
// Frame layout: LEN_LO, LEN_HI, L payload bytes, CSUM.
package uart_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CSUM,
      DONE,
      ERR
   } loader_state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_LEN     = 2'b01,
      ERR_CSUM    = 2'b10,
      ERR_TIMEOUT = 2'b11
   } err_code_t;

   localparam int HDR_BYTES  = 2;
   localparam int CSUM_BYTES = 1;

   // True while a frame is being received.
   function automatic logic is_busy_state(input loader_state_t s);
      return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
   endfunction

endpackage

// File: rtl/loader_watchdog.sv
// Inter-byte idle counter: expires after TIMEOUT_CYC enabled cycles without a clear.
// The count saturates at the limit so o_expired stays asserted until cleared.
module loader_watchdog #(
   parameter int TIMEOUT_CYC = 100000,
   parameter int TO_W        = 17
) (
   input  logic clk,
   input  logic Rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (Rst || i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != LIMIT)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/uart_mem_loader.sv
// Boot loader: parses a length-prefixed, checksummed UART frame and writes the
// payload into byte memory from address 0, holding the CPU in reset meanwhile.
module uart_mem_loader
   import uart_loader_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int DEPTH       = 1024,
   parameter int TIMEOUT_CYC = 100000,
   parameter int TO_W        = 17
) (
   input  logic              clk,
   input  logic              Rst,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              mem_en,
   output logic              mem_wea,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_din,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   byte_count
);

   localparam logic [15:0] MAX_LEN = 16'(DEPTH);

   loader_state_t     r_state, w_state_next;
   err_code_t         r_err_code, w_err_code_next;
   logic [7:0]        r_len_lo, w_len_lo_next;
   logic [ADDR_W:0]   r_len, w_len_next;
   logic [ADDR_W:0]   r_byte_count, w_byte_count_next;
   logic [7:0]        r_csum, w_csum_next;
   logic              r_mem_we, w_mem_we_next;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
   logic [7:0]        r_mem_din, w_mem_din_next;

   logic              w_in_frame;
   logic              w_wd_enable;
   logic              w_wd_clear;
   logic              w_wd_expired;
   logic [15:0]       w_len_full;
   logic [ADDR_W:0]   w_count_inc;

   assign w_in_frame  = is_busy_state(r_state);
   assign w_wd_enable = (r_state == LEN_HI) || (r_state == DATA) || (r_state == CSUM);
   // Every accepted byte (and the arming start) restarts the idle window.
   assign w_wd_clear  = (start && !w_in_frame) || (rx_valid && w_in_frame);
   assign w_len_full  = {rx_data, r_len_lo};
   assign w_count_inc = r_byte_count + 1'b1;

   loader_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TO_W        (TO_W)
   ) u_watchdog (
      .clk       (clk),
      .Rst       (Rst),
      .i_clear   (w_wd_clear),
      .i_enable  (w_wd_enable),
      .o_expired (w_wd_expired)
   );

   always_ff @(posedge clk) begin
      if (Rst) begin
         r_state      <= IDLE;
         r_err_code   <= ERR_NONE;
         r_len_lo     <= '0;
         r_len        <= '0;
         r_byte_count <= '0;
         r_csum       <= '0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_din    <= '0;
      end else begin
         r_state      <= w_state_next;
         r_err_code   <= w_err_code_next;
         r_len_lo     <= w_len_lo_next;
         r_len        <= w_len_next;
         r_byte_count <= w_byte_count_next;
         r_csum       <= w_csum_next;
         r_mem_we     <= w_mem_we_next;
         r_mem_addr   <= w_mem_addr_next;
         r_mem_din    <= w_mem_din_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_err_code_next   = r_err_code;
      w_len_lo_next     = r_len_lo;
      w_len_next        = r_len;
      w_byte_count_next = r_byte_count;
      w_csum_next       = r_csum;
      w_mem_we_next     = 1'b0;
      w_mem_addr_next   = r_mem_addr;
      w_mem_din_next    = r_mem_din;

      case (r_state)
         IDLE, DONE, ERR: begin
            // A byte arriving with start is dropped: the frame begins with the next byte.
            if (start) begin
               w_state_next      = LEN_LO;
               w_err_code_next   = ERR_NONE;
               w_byte_count_next = '0;
               w_csum_next       = '0;
            end
         end
         LEN_LO: begin
            if (rx_valid) begin
               w_len_lo_next = rx_data;
               w_state_next  = LEN_HI;
            end
         end
         LEN_HI: begin
            if (rx_valid) begin
               if ((w_len_full == 16'd0) || (w_len_full > MAX_LEN)) begin
                  w_state_next    = ERR;
                  w_err_code_next = ERR_LEN;
               end else begin
                  w_len_next   = w_len_full[ADDR_W:0];
                  w_state_next = DATA;
               end
            end else if (w_wd_expired) begin
               w_state_next    = ERR;
               w_err_code_next = ERR_TIMEOUT;
            end
         end
         DATA: begin
            if (rx_valid) begin
               w_mem_we_next     = 1'b1;
               w_mem_addr_next   = r_byte_count[ADDR_W-1:0];
               w_mem_din_next    = rx_data;
               w_byte_count_next = w_count_inc;
               w_csum_next       = r_csum + rx_data;
               if (w_count_inc == r_len) begin
                  w_state_next = CSUM;
               end
            end else if (w_wd_expired) begin
               w_state_next    = ERR;
               w_err_code_next = ERR_TIMEOUT;
            end
         end
         CSUM: begin
            if (rx_valid) begin
               if (rx_data == r_csum) begin
                  w_state_next = DONE;
               end else begin
                  w_state_next    = ERR;
                  w_err_code_next = ERR_CSUM;
               end
            end else if (w_wd_expired) begin
               w_state_next    = ERR;
               w_err_code_next = ERR_TIMEOUT;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign mem_en     = r_mem_we;
   assign mem_wea    = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_din    = r_mem_din;
   assign busy       = w_in_frame;
   assign cpu_hold   = w_in_frame;
   assign done       = (r_state == DONE);
   assign error      = (r_state == ERR);
   assign err_code   = r_err_code;
   assign byte_count = r_byte_count;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: table of whole frames plus hand-written
// sequences for timeout, reset, ignore rules, back-to-back bytes and max length.
module tb_uart_mem_loader;

   localparam int ADDR_W      = 10;
   localparam int DEPTH       = 1024;
   localparam int TIMEOUT_CYC = 50;
   localparam int TO_W        = 6;

   logic              clk = 1'b0;
   logic              Rst;
   logic              start;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              mem_en;
   logic              mem_wea;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_din;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              error;
   logic [1:0]        err_code;
   logic [ADDR_W:0]   byte_count;

   uart_mem_loader #(
      .ADDR_W      (ADDR_W),
      .DEPTH       (DEPTH),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TO_W        (TO_W)
   ) dut (
      .clk        (clk),
      .Rst        (Rst),
      .start      (start),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .mem_en     (mem_en),
      .mem_wea    (mem_wea),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_code   (err_code),
      .byte_count (byte_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int wr_count = 0;

   always @(posedge clk) begin
      if (mem_wea === 1'b1 && mem_en === 1'b1) wr_count <= wr_count + 1;
   end

   typedef struct {
      logic [63:0] bytes;
      int          nbytes;
      logic        exp_done;
      logic        exp_error;
      logic [1:0]  exp_code;
      int          exp_bc;
      int          exp_nwr;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s = 0x%0h", name, act);
      end
   endtask

   // Called at a falling edge: byte is sampled on the next rising edge,
   // and the write (if any) must be visible in the following cycle.
   task automatic send(input logic [7:0] b, input bit exp_wr, input int exp_addr, input string tag);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      chk({tag, " wea"}, 32'(mem_wea), exp_wr ? 32'd1 : 32'd0);
      chk({tag, " en"}, 32'(mem_en), exp_wr ? 32'd1 : 32'd0);
      if (exp_wr) begin
         chk({tag, " addr"}, 32'(mem_addr), 32'(exp_addr));
         chk({tag, " din"}, 32'(mem_din), 32'(b));
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic chk_status(input string tag, input int e_busy, input int e_done,
                             input int e_err, input int e_code, input int e_bc);
      chk({tag, " busy"}, 32'(busy), 32'(e_busy));
      chk({tag, " cpu_hold"}, 32'(cpu_hold), 32'(e_busy));
      chk({tag, " done"}, 32'(done), 32'(e_done));
      chk({tag, " error"}, 32'(error), 32'(e_err));
      chk({tag, " err_code"}, 32'(err_code), 32'(e_code));
      chk({tag, " byte_count"}, 32'(byte_count), 32'(e_bc));
   endtask

   initial begin
      logic [63:0] fb;
      logic [7:0]  b;
      int          len;
      int          wr0;
      bit          ew;

      vecs[0] = '{64'h0000_6633_2211_0003, 6, 1'b1, 1'b0, 2'b00, 3, 3};
      vecs[1] = '{64'h0000_0000_55AA_0002, 5, 1'b0, 1'b1, 2'b10, 2, 2};
      vecs[2] = '{64'h0000_0000_0000_0000, 2, 1'b0, 1'b1, 2'b01, 0, 0};
      vecs[3] = '{64'h0000_0000_0000_0401, 2, 1'b0, 1'b1, 2'b01, 0, 0};
      vecs[4] = '{64'h0000_0001_02FF_0002, 5, 1'b1, 1'b0, 2'b00, 2, 2};
      vecs[5] = '{64'h0000_0000_807F_0001, 4, 1'b0, 1'b1, 2'b10, 1, 1};

      Rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      chk_status("reset", 0, 0, 0, 0, 0);
      chk("reset mem_wea", 32'(mem_wea), 0);
      chk("reset mem_addr", 32'(mem_addr), 0);
      chk("reset mem_din", 32'(mem_din), 0);
      Rst = 1'b0;
      @(negedge clk);

      // rx_valid in IDLE is ignored
      wr0 = wr_count;
      send(8'h03, 1'b0, 0, "idle rx0");
      send(8'h00, 1'b0, 0, "idle rx1");
      @(negedge clk);
      chk("idle no writes", 32'(wr_count - wr0), 0);
      chk_status("idle after rx", 0, 0, 0, 0, 0);

      for (int v = 0; v < 6; v++) begin
         wr0 = wr_count;
         fb  = vecs[v].bytes;
         len = int'({fb[15:8], fb[7:0]});
         pulse_start();
         chk_status($sformatf("v%0d armed", v), 1, 0, 0, 0, 0);
         for (int i = 0; i < vecs[v].nbytes; i++) begin
            b  = fb[8*i +: 8];
            ew = (len >= 1) && (len <= DEPTH) && (i >= 2) && (i < 2 + len);
            send(b, ew, i - 2, $sformatf("v%0d b%0d", v, i));
         end
         chk_status($sformatf("v%0d end", v), 0, int'(vecs[v].exp_done),
                    int'(vecs[v].exp_error), int'(vecs[v].exp_code), vecs[v].exp_bc);
         @(negedge clk);
         chk($sformatf("v%0d writes", v), 32'(wr_count - wr0), 32'(vecs[v].exp_nwr));
      end

      // Timeout: a byte on the last allowed idle cycle is accepted; silence then expires
      pulse_start();
      send(8'h01, 1'b0, 0, "to len_lo");
      send(8'h00, 1'b0, 0, "to len_hi");
      repeat (TIMEOUT_CYC - 2) @(negedge clk);
      chk_status("to before late byte", 1, 0, 0, 0, 0);
      send(8'h5C, 1'b1, 0, "to late byte");
      repeat (TIMEOUT_CYC - 1) @(negedge clk);
      chk_status("to last idle cycle", 1, 0, 0, 0, 1);
      @(negedge clk);
      chk_status("to expired", 0, 0, 1, 3, 1);

      // Reset in the middle of DATA
      pulse_start();
      send(8'h04, 1'b0, 0, "rst len_lo");
      send(8'h00, 1'b0, 0, "rst len_hi");
      send(8'hA1, 1'b1, 0, "rst d0");
      send(8'hB2, 1'b1, 1, "rst d1");
      Rst = 1'b1;
      @(negedge clk);
      Rst = 1'b0;
      chk_status("rst mid", 0, 0, 0, 0, 0);
      chk("rst mid mem_wea", 32'(mem_wea), 0);
      chk("rst mid mem_en", 32'(mem_en), 0);
      chk("rst mid mem_addr", 32'(mem_addr), 0);
      chk("rst mid mem_din", 32'(mem_din), 0);
      wr0 = wr_count;
      send(8'hC3, 1'b0, 0, "rst post rx0");
      send(8'hD4, 1'b0, 0, "rst post rx1");
      @(negedge clk);
      chk("rst post no writes", 32'(wr_count - wr0), 0);

      // start during DATA does not restart the frame
      pulse_start();
      send(8'h03, 1'b0, 0, "sd len_lo");
      send(8'h00, 1'b0, 0, "sd len_hi");
      send(8'h11, 1'b1, 0, "sd d0");
      pulse_start();
      chk_status("sd start ignored", 1, 0, 0, 0, 1);
      send(8'h22, 1'b1, 1, "sd d1");
      send(8'h33, 1'b1, 2, "sd d2");
      send(8'h66, 1'b0, 0, "sd csum");
      chk_status("sd end", 0, 1, 0, 0, 3);

      // start and rx_valid together: the byte is discarded
      start = 1'b1; rx_valid = 1'b1; rx_data = 8'h02;
      @(negedge clk);
      start = 1'b0; rx_valid = 1'b0;
      chk_status("srx armed", 1, 0, 0, 0, 0);
      send(8'h01, 1'b0, 0, "srx len_lo");
      send(8'h00, 1'b0, 0, "srx len_hi");
      send(8'h55, 1'b1, 0, "srx d0");
      send(8'h55, 1'b0, 0, "srx csum");
      chk_status("srx end", 0, 1, 0, 0, 1);

      // Back-to-back bytes in consecutive cycles
      pulse_start();
      send(8'h04, 1'b0, 0, "b2b len_lo");
      send(8'h00, 1'b0, 0, "b2b len_hi");
      for (int i = 0; i < 4; i++) begin
         rx_data  = 8'(16 * (i + 1));
         rx_valid = 1'b1;
         @(negedge clk);
         chk($sformatf("b2b w%0d wea", i), 32'(mem_wea), 1);
         chk($sformatf("b2b w%0d addr", i), 32'(mem_addr), 32'(i));
         chk($sformatf("b2b w%0d din", i), 32'(mem_din), 32'(16 * (i + 1)));
      end
      rx_data = 8'hA0;
      @(negedge clk);
      rx_valid = 1'b0;
      chk("b2b csum wea", 32'(mem_wea), 0);
      chk_status("b2b end", 0, 1, 0, 0, 4);

      // Maximum length: 1024 bytes of i[7:0], which sum to 0 mod 256
      pulse_start();
      send(8'h00, 1'b0, 0, "max len_lo");
      send(8'h04, 1'b0, 0, "max len_hi");
      for (int i = 0; i < DEPTH; i++) begin
         send(8'(i), 1'b1, i, "max d");
      end
      chk("max last addr", 32'(mem_addr), 32'h3FF);
      send(8'h00, 1'b0, 0, "max csum");
      chk_status("max end", 0, 1, 0, 0, 1024);
      chk("max addr holds", 32'(mem_addr), 32'h3FF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Boot loader that sits directly upstream of the byte-wide program/data memory (1024 x 8, synchronous write on wea & En, 1-cycle read).
- Consumes bytes from the UART receiver, parses a length-prefixed, checksummed frame, and writes the payload into memory at consecutive addresses from 0.
- Holds the CPU in reset while loading and reports done or error status.

Parameters:
- ADDR_W, 10, memory address width.
- DEPTH, 1024, memory depth in bytes. Maximum legal payload length.
- TIMEOUT_CYC, 100000, maximum idle clk cycles allowed between consecutive frame bytes once a frame has started.
- TO_W, 17, width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock.
- Rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that arms the loader.
- rx_valid  in  1  single-cycle strobe from the UART receiver; rx_data is valid in this cycle.
- rx_data  in  8  received byte.
- mem_en  out  1  memory enable.
- mem_wea  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  8  memory write data.
- cpu_hold  out  1  high while busy. Keeps the core in reset.
- busy  out  1  frame reception in progress.
- done  out  1  sticky: last frame loaded successfully.
- error  out  1  sticky: last frame failed.
- err_code  out  2  error code: 00 none, 01 bad length, 10 checksum mismatch, 11 timeout.
- byte_count  out  ADDR_W+1  payload bytes written in the current or last frame.

Behaviour:
- Reset: Rst is synchronous, active-high; clock is clk. On Rst, all outputs are 0, the FSM goes to IDLE, and counters clear.
- Frame format: LEN_LO, LEN_HI (16-bit little-endian length L), then L payload bytes, then CSUM. CSUM is the 8-bit sum mod 256 of the payload bytes.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR on start → LEN_LO:
  - clears done, error, err_code, byte_count, checksum accumulator, and timeout counter;
  - sets busy and cpu_hold.
- LEN_LO on rx_valid: latch the low byte → LEN_HI.
- LEN_HI on rx_valid: form L.
  - L == 0 or L > DEPTH → ERR, code 01.
  - Otherwise → DATA.
- DATA on rx_valid:
  - In the next cycle, mem_en = mem_wea = 1 for exactly one cycle, with mem_addr = byte_count[ADDR_W-1:0] and mem_din = the byte.
  - byte_count increments and the accumulator adds the byte.
  - When byte_count reaches L → CSUM.
  - Outside write cycles, mem_en = mem_wea = 0. mem_addr and mem_din hold their last value.
- CSUM on rx_valid:
  - Byte equals accumulator → DONE.
  - Otherwise → ERR, code 10.
- Write latency: exactly 1 cycle from rx_valid to mem_wea. Writes never wrap, because L ≤ DEPTH.
- Timeout:
  - The counter runs in LEN_HI, DATA, and CSUM, and resets on every accepted rx_valid.
  - Reaching TIMEOUT_CYC → ERR, code 11.
  - LEN_LO waits indefinitely.
- DONE/ERR: busy = 0, cpu_hold = 0. done or error stays high until the next start or Rst.
- start while busy is ignored.
- rx_valid in IDLE, DONE, or ERR is ignored. No memory write occurs.
- start and rx_valid in the same cycle in IDLE: start takes effect and the byte is discarded.
- rx_valid in the same cycle the timeout expires: the byte wins and the counter resets.
- Back-to-back rx_valid in consecutive cycles must be accepted with no loss. Each produces one write, one cycle later.
- Rst mid-frame: immediate return to IDLE with all outputs 0. Memory contents already written are left unchanged.
- An error mid-DATA leaves already-written bytes in memory. No rollback.

Decomposition:
- Package uart_loader_pkg holds:
  - loader_state_t enum (7 states);
  - err_code_t enum (ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT);
  - frame constants (HDR_BYTES = 2, CSUM_BYTES = 1).
- One sub-module, loader_watchdog: a TO_W-bit counter with clear, enable, and an expired output.
- Everything else is in a single FSM plus datapath.

Test Plan:
- Normal load: start, then bytes 03 00 11 22 33 66 → three writes (addr 0 = 11, addr 1 = 22, addr 2 = 33), each 1 cycle after its rx_valid; then done = 1, byte_count = 3, cpu_hold = 0.
- Bad checksum: start, then 02 00 AA 55 00 → writes at addr 0 and addr 1 occur; then error = 1, err_code = 10, done = 0.
- Length bounds: L = 0x0000 → ERR, code 01, no writes. L = 0x0401 → ERR, code 01. L = 0x0400 with 1024 bytes and correct CSUM → done, last write at addr 0x3FF, no wrap.
- Timeout: start, 01 00, then silence for TIMEOUT_CYC cycles → error = 1, err_code = 11. A byte arriving at cycle TIMEOUT_CYC−1 must not time out.
- Reset mid-DATA: Rst asserted after the 2nd of 4 payload bytes → the next cycle shows all outputs 0 and the FSM in IDLE. Subsequent rx_valid produces no writes until start.
- Ignore rules: rx_valid in IDLE produces no write. start during DATA does not restart the frame. Back-to-back rx_valid in consecutive cycles produces consecutive writes at addr n and n+1.
